// File: rtl/lsu_am.sv
// Address-mux arbiter for the LSU_EX slot: picks between LSU_ID ops, LQ replays
// and SQ retiring stores, registers the winner, and returns per-requester stalls.
module lsu_am #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int TAG_WIDTH    = 6,
    parameter int FUNC_WIDTH   = 4,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_WIDTH    = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_flush,
    input  logic                  i_ex_stall,
    input  logic                  i_id_valid,
    input  logic [ADDR_WIDTH-1:0] i_id_addr,
    input  logic [FUNC_WIDTH-1:0] i_id_lsu_func,
    input  logic [TAG_WIDTH-1:0]  i_id_tag,
    output logic                  o_id_stall,
    input  logic                  i_replay_en,
    input  logic [ADDR_WIDTH-1:0] i_replay_addr,
    input  logic [FUNC_WIDTH-1:0] i_replay_lsu_func,
    input  logic [TAG_WIDTH-1:0]  i_replay_tag,
    output logic                  o_replay_stall,
    input  logic                  i_sq_retire_en,
    input  logic [ADDR_WIDTH-1:0] i_sq_retire_addr,
    input  logic [FUNC_WIDTH-1:0] i_sq_retire_lsu_func,
    input  logic [TAG_WIDTH-1:0]  i_sq_retire_tag,
    input  logic [DATA_WIDTH-1:0] i_sq_retire_data,
    output logic                  o_sq_retire_stall,
    output logic                  o_ex_valid,
    output logic [ADDR_WIDTH-1:0] o_ex_addr,
    output logic [FUNC_WIDTH-1:0] o_ex_lsu_func,
    output logic [TAG_WIDTH-1:0]  o_ex_tag,
    output logic [DATA_WIDTH-1:0] o_ex_data,
    output logic [1:0]            o_ex_src
);

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_ID   = 2'd1;
    localparam logic [1:0] SRC_RP   = 2'd2;
    localparam logic [1:0] SRC_SQ   = 2'd3;
    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

    // Handshake: a requester's op transfers on a clock edge where its request is
    // high and its stall is low; while stalled it must hold request and payload.
    logic                 advance;
    logic                 id_req, rp_req, sq_req;
    logic                 gnt_id, gnt_rp, gnt_sq;
    logic [CNT_WIDTH-1:0] cnt_id, cnt_rp;

    assign advance = ~o_ex_valid | ~i_ex_stall;

    // Flush kills speculative ID/replay traffic; committed stores still flow.
    assign id_req = i_id_valid & ~i_flush;
    assign rp_req = i_replay_en & ~i_flush;
    assign sq_req = i_sq_retire_en;

    always_comb begin
        gnt_id = 1'b0;
        gnt_rp = 1'b0;
        gnt_sq = 1'b0;
        if (advance && !rst) begin
            if (rp_req && cnt_rp == LIMIT)      gnt_rp = 1'b1;
            else if (id_req && cnt_id == LIMIT) gnt_id = 1'b1;
            else if (sq_req)                    gnt_sq = 1'b1;
            else if (rp_req)                    gnt_rp = 1'b1;
            else if (id_req)                    gnt_id = 1'b1;
        end
    end

    assign o_id_stall        = id_req & ~gnt_id;
    assign o_replay_stall    = rp_req & ~gnt_rp;
    assign o_sq_retire_stall = sq_req & ~gnt_sq;

    function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] cnt,
                                                      input logic req, input logic gnt,
                                                      input logic adv);
        if (!req)             return '0;
        else if (!adv)        return cnt;
        else if (gnt)         return '0;
        else if (cnt == LIMIT) return cnt;
        else                  return cnt + CNT_WIDTH'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_id <= '0;
            cnt_rp <= '0;
        end else begin
            cnt_id <= cnt_next(cnt_id, id_req, gnt_id, advance);
            cnt_rp <= cnt_next(cnt_rp, rp_req, gnt_rp, advance);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_ex_valid    <= 1'b0;
            o_ex_addr     <= '0;
            o_ex_lsu_func <= '0;
            o_ex_tag      <= '0;
            o_ex_data     <= '0;
            o_ex_src      <= SRC_NONE;
        end else if (advance) begin
            if (gnt_sq) begin
                o_ex_valid    <= 1'b1;
                o_ex_addr     <= i_sq_retire_addr;
                o_ex_lsu_func <= i_sq_retire_lsu_func;
                o_ex_tag      <= i_sq_retire_tag;
                o_ex_data     <= i_sq_retire_data;
                o_ex_src      <= SRC_SQ;
            end else if (gnt_rp) begin
                o_ex_valid    <= 1'b1;
                o_ex_addr     <= i_replay_addr;
                o_ex_lsu_func <= i_replay_lsu_func;
                o_ex_tag      <= i_replay_tag;
                o_ex_data     <= '0;
                o_ex_src      <= SRC_RP;
            end else if (gnt_id) begin
                o_ex_valid    <= 1'b1;
                o_ex_addr     <= i_id_addr;
                o_ex_lsu_func <= i_id_lsu_func;
                o_ex_tag      <= i_id_tag;
                o_ex_data     <= '0;
                o_ex_src      <= SRC_ID;
            end else begin
                o_ex_valid    <= 1'b0;
                o_ex_src      <= SRC_NONE;
            end
        end else if (i_flush && (o_ex_src == SRC_ID || o_ex_src == SRC_RP)) begin
            // A held speculative op is dropped even while EX is stalled.
            o_ex_valid <= 1'b0;
            o_ex_src   <= SRC_NONE;
        end
    end

endmodule

// File: tb/tb_lsu_am.sv
// Directed bench for lsu_am: reset, priority, starvation, stall hold, flush
// and mid-operation reset, with hand-computed expectations.
module tb_lsu_am;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_flush, i_ex_stall;
    logic        i_id_valid;
    logic [31:0] i_id_addr;
    logic [3:0]  i_id_lsu_func;
    logic [5:0]  i_id_tag;
    logic        o_id_stall;
    logic        i_replay_en;
    logic [31:0] i_replay_addr;
    logic [3:0]  i_replay_lsu_func;
    logic [5:0]  i_replay_tag;
    logic        o_replay_stall;
    logic        i_sq_retire_en;
    logic [31:0] i_sq_retire_addr;
    logic [3:0]  i_sq_retire_lsu_func;
    logic [5:0]  i_sq_retire_tag;
    logic [31:0] i_sq_retire_data;
    logic        o_sq_retire_stall;
    logic        o_ex_valid;
    logic [31:0] o_ex_addr;
    logic [3:0]  o_ex_lsu_func;
    logic [5:0]  o_ex_tag;
    logic [31:0] o_ex_data;
    logic [1:0]  o_ex_src;

    int n_tests = 0;
    int n_fail  = 0;
    logic [1:0] exp_q[$];

    lsu_am dut (
        .clk(clk), .rst(rst), .i_flush(i_flush), .i_ex_stall(i_ex_stall),
        .i_id_valid(i_id_valid), .i_id_addr(i_id_addr), .i_id_lsu_func(i_id_lsu_func),
        .i_id_tag(i_id_tag), .o_id_stall(o_id_stall),
        .i_replay_en(i_replay_en), .i_replay_addr(i_replay_addr),
        .i_replay_lsu_func(i_replay_lsu_func), .i_replay_tag(i_replay_tag),
        .o_replay_stall(o_replay_stall),
        .i_sq_retire_en(i_sq_retire_en), .i_sq_retire_addr(i_sq_retire_addr),
        .i_sq_retire_lsu_func(i_sq_retire_lsu_func), .i_sq_retire_tag(i_sq_retire_tag),
        .i_sq_retire_data(i_sq_retire_data), .o_sq_retire_stall(o_sq_retire_stall),
        .o_ex_valid(o_ex_valid), .o_ex_addr(o_ex_addr), .o_ex_lsu_func(o_ex_lsu_func),
        .o_ex_tag(o_ex_tag), .o_ex_data(o_ex_data), .o_ex_src(o_ex_src)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_reqs();
        i_id_valid     = 1'b0;
        i_replay_en    = 1'b0;
        i_sq_retire_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; i_flush = 1'b0; i_ex_stall = 1'b0;
        clear_reqs();
        i_id_addr = '0; i_id_lsu_func = '0; i_id_tag = '0;
        i_replay_addr = '0; i_replay_lsu_func = '0; i_replay_tag = '0;
        i_sq_retire_addr = '0; i_sq_retire_lsu_func = '0; i_sq_retire_tag = '0;
        i_sq_retire_data = '0;
        tick(); tick();

        // Reset state
        chk("rst_valid", 64'(o_ex_valid), 64'd0);
        chk("rst_src", 64'(o_ex_src), 64'd0);
        chk("rst_addr", 64'(o_ex_addr), 64'd0);
        chk("rst_data", 64'(o_ex_data), 64'd0);
        chk("rst_cnt_id", 64'(dut.cnt_id), 64'd0);
        chk("rst_cnt_rp", 64'(dut.cnt_rp), 64'd0);
        chk("rst_stalls", 64'({o_id_stall, o_replay_stall, o_sq_retire_stall}), 64'd0);
        rst = 1'b0;

        // Single ID op
        i_id_valid = 1'b1; i_id_addr = 32'h100; i_id_tag = 6'd5; i_id_lsu_func = 4'd3;
        #1 chk("id_stall0", 64'(o_id_stall), 64'd0);
        tick();
        chk("id_valid", 64'(o_ex_valid), 64'd1);
        chk("id_addr", 64'(o_ex_addr), 64'h100);
        chk("id_tag", 64'(o_ex_tag), 64'd5);
        chk("id_func", 64'(o_ex_lsu_func), 64'd3);
        chk("id_src", 64'(o_ex_src), 64'd1);
        chk("id_data", 64'(o_ex_data), 64'd0);
        clear_reqs();

        // All three request: SQ first, then replay once SQ retires
        i_id_valid = 1'b1; i_id_addr = 32'h200; i_id_tag = 6'd7;
        i_replay_en = 1'b1; i_replay_addr = 32'h300; i_replay_tag = 6'd9;
        i_sq_retire_en = 1'b1; i_sq_retire_addr = 32'h400; i_sq_retire_tag = 6'd11;
        i_sq_retire_data = 32'hdeadbeef;
        #1;
        chk("all3_id_stall", 64'(o_id_stall), 64'd1);
        chk("all3_rp_stall", 64'(o_replay_stall), 64'd1);
        chk("all3_sq_stall", 64'(o_sq_retire_stall), 64'd0);
        tick();
        chk("all3_src", 64'(o_ex_src), 64'd3);
        chk("all3_addr", 64'(o_ex_addr), 64'h400);
        chk("all3_data", 64'(o_ex_data), 64'hdeadbeef);
        chk("all3_cnt_rp", 64'(dut.cnt_rp), 64'd1);
        chk("all3_cnt_id", 64'(dut.cnt_id), 64'd1);
        i_sq_retire_en = 1'b0;
        #1 chk("rp_next_stall", 64'(o_replay_stall), 64'd0);
        tick();
        chk("rp_src", 64'(o_ex_src), 64'd2);
        chk("rp_addr", 64'(o_ex_addr), 64'h300);
        chk("rp_data", 64'(o_ex_data), 64'd0);
        chk("rp_cnt_id", 64'(dut.cnt_id), 64'd2);
        clear_reqs();
        tick();
        chk("idle_valid", 64'(o_ex_valid), 64'd0);
        chk("idle_cnt_id", 64'(dut.cnt_id), 64'd0);

        // Starvation: SQ+replay held, ID joins on the replay force-grant cycle
        exp_q = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd2, 2'd3, 2'd3, 2'd3, 2'd1};
        i_sq_retire_en = 1'b1; i_replay_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i == 4) i_id_valid = 1'b1;
            tick();
            chk($sformatf("starve_src_%0d", i), 64'(o_ex_src), 64'(exp_q.pop_front()));
        end
        chk("starve_cnt_rp", 64'(dut.cnt_rp), 64'd4);
        chk("starve_cnt_id", 64'(dut.cnt_id), 64'd0);

        // Downstream stall holds everything
        i_ex_stall = 1'b1;
        #1 chk("hold_stalls", 64'({o_id_stall, o_replay_stall, o_sq_retire_stall}), 64'h7);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("hold_src_%0d", i), 64'(o_ex_src), 64'd1);
            chk($sformatf("hold_addr_%0d", i), 64'(o_ex_addr), 64'h200);
            chk($sformatf("hold_cnts_%0d", i), 64'({dut.cnt_rp, dut.cnt_id}), 64'({3'd4, 3'd0}));
        end
        i_ex_stall = 1'b0;
        #1 chk("release_rp_stall", 64'(o_replay_stall), 64'd0);
        tick();
        chk("release_src", 64'(o_ex_src), 64'd2);
        clear_reqs();
        tick();

        // Flush drops a held replay op
        i_replay_en = 1'b1; i_replay_addr = 32'h500;
        tick();
        chk("fl_rp_src", 64'(o_ex_src), 64'd2);
        clear_reqs(); i_ex_stall = 1'b1;
        tick();
        chk("fl_rp_hold", 64'(o_ex_valid), 64'd1);
        i_flush = 1'b1;
        tick();
        chk("fl_rp_valid", 64'(o_ex_valid), 64'd0);
        chk("fl_rp_srcclr", 64'(o_ex_src), 64'd0);
        i_flush = 1'b0;

        // Flush keeps a held SQ op
        i_sq_retire_en = 1'b1; i_sq_retire_data = 32'h12345678;
        tick();
        chk("fl_sq_src", 64'(o_ex_src), 64'd3);
        clear_reqs();
        i_flush = 1'b1;
        tick();
        chk("fl_sq_valid", 64'(o_ex_valid), 64'd1);
        chk("fl_sq_keep", 64'(o_ex_src), 64'd3);
        chk("fl_sq_data", 64'(o_ex_data), 64'h12345678);

        // Flush with all three requesting and advance=1
        i_ex_stall = 1'b0;
        i_id_valid = 1'b1; i_replay_en = 1'b1; i_sq_retire_en = 1'b1;
        i_sq_retire_data = 32'hcafef00d;
        #1 chk("fl_all_stalls", 64'({o_id_stall, o_replay_stall, o_sq_retire_stall}), 64'd0);
        tick();
        chk("fl_all_src", 64'(o_ex_src), 64'd3);
        chk("fl_all_data", 64'(o_ex_data), 64'hcafef00d);
        chk("fl_all_cnts", 64'({dut.cnt_rp, dut.cnt_id}), 64'd0);
        i_flush = 1'b0;
        clear_reqs();
        tick();

        // Reset mid-operation with cnt_id=3
        i_sq_retire_en = 1'b1; i_id_valid = 1'b1;
        tick(); tick(); tick();
        chk("mid_cnt_id", 64'(dut.cnt_id), 64'd3);
        chk("mid_src", 64'(o_ex_src), 64'd3);
        rst = 1'b1;
        #1 chk("mid_rst_sq_stall", 64'(o_sq_retire_stall), 64'd1);
        tick();
        chk("mid_rst_valid", 64'(o_ex_valid), 64'd0);
        chk("mid_rst_src", 64'(o_ex_src), 64'd0);
        chk("mid_rst_cnts", 64'({dut.cnt_rp, dut.cnt_id}), 64'd0);
        rst = 1'b0;
        clear_reqs();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
